lpc_host_io: RTL and testbench



---
 rtl/lpc_host_io_pkg.sv | 25 ++
 rtl/lpc_host_sync_mon.sv | 54 +++++
 rtl/lpc_host_io.sv | 161 ++++++++++++++++
 tb/tb_lpc_host_io.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lpc_host_io_pkg.sv
// Shared LPC host definitions: host state encodings, LAD nibble codes and response status codes.
package lpc_host_io_pkg;

  typedef enum logic [4:0] {
    ST_IDLE, ST_START, ST_CYCTYPE, ST_ADDR1, ST_ADDR2, ST_ADDR3, ST_ADDR4,
    ST_WDATA1, ST_WDATA2, ST_TAR1, ST_TAR2, ST_SYNC, ST_RDATA1, ST_RDATA2,
    ST_FTAR1, ST_FTAR2, ST_ABORT
  } host_state_e;

  localparam logic [3:0] LPC_START    = 4'h0;
  localparam logic [3:0] LPC_CT_IO_RD = 4'h0;
  localparam logic [3:0] LPC_CT_IO_WR = 4'h2;
  localparam logic [3:0] LPC_LAD_IDLE = 4'hF;

  localparam logic [3:0] SYNC_READY      = 4'h0;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'h5;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'h6;
  localparam logic [3:0] SYNC_ERROR      = 4'hA;
  localparam logic [3:0] SYNC_NONE       = 4'hF;

  localparam logic [1:0] RSP_OK    = 2'b00;
  localparam logic [1:0] RSP_ERR   = 2'b01;
  localparam logic [1:0] RSP_ABORT = 2'b10;

endpackage

// File: rtl/lpc_host_sync_mon.sv
// SYNC decoder with saturating short/long wait counters; tells the host FSM to proceed or abort.
module lpc_host_sync_mon
  import lpc_host_io_pkg::*;
#(
  parameter int SYNC_TIMEOUT  = 8,
  parameter int LONG_WAIT_MAX = 1024
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       en_i,
  input  logic [3:0] lad_i,
  output logic       go_o,
  output logic       err_o,
  output logic       abort_o
);

  localparam int SW = $clog2(SYNC_TIMEOUT + 1);
  localparam int LW = $clog2(LONG_WAIT_MAX + 1);
  localparam logic [SW-1:0] SHORT_LIM  = SW'(SYNC_TIMEOUT);
  localparam logic [SW-1:0] SHORT_LAST = SW'(SYNC_TIMEOUT - 1);
  localparam logic [LW-1:0] LONG_LIM   = LW'(LONG_WAIT_MAX);
  localparam logic [LW-1:0] LONG_LAST  = LW'(LONG_WAIT_MAX - 1);

  logic [SW-1:0] short_q;
  logic [LW-1:0] long_q;
  logic          is_ready, is_err, is_short, is_long;

  // Abort fires on the sample that would bring a counter up to its limit.
  always_comb begin
    is_ready = (lad_i == SYNC_READY);
    is_err   = (lad_i == SYNC_ERROR);
    is_short = (lad_i == SYNC_SHORT_WAIT) || (lad_i == SYNC_NONE);
    is_long  = (lad_i == SYNC_LONG_WAIT);
    go_o     = en_i && (is_ready || is_err);
    err_o    = en_i && is_err;
    abort_o  = en_i && ((is_short && (short_q >= SHORT_LAST)) ||
                        (is_long && (long_q >= LONG_LAST)) ||
                        !(is_ready || is_err || is_short || is_long));
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      short_q <= '0;
      long_q  <= '0;
    end else if (!en_i) begin
      short_q <= '0;
      long_q  <= '0;
    end else begin
      if (is_short && (short_q != SHORT_LIM)) short_q <= short_q + 1'b1;
      if (is_long && (long_q != LONG_LIM))    long_q  <= long_q + 1'b1;
    end
  end

endmodule

// File: rtl/lpc_host_io.sv
// LPC host initiator for single-byte I/O read/write cycles with SYNC wait handling and abort.
//
// state    | meaning
// IDLE     | bus released, ready for a request
// START    | LFRAME# low, LAD=0
// CYCTYPE  | I/O read/write cycle type nibble
// ADDR1..4 | address nibbles, MSN first
// WDATA1/2 | write data nibbles, LSN first
// TAR1/2   | turnaround to peripheral
// SYNC     | wait for peripheral SYNC
// RDATA1/2 | capture read data nibbles
// FTAR1/2  | final turnaround, then respond
// ABORT    | LFRAME# low, LAD=F for ABORT_CLKS cycles
module lpc_host_io
  import lpc_host_io_pkg::*;
#(
  parameter int SYNC_TIMEOUT  = 8,
  parameter int LONG_WAIT_MAX = 1024,
  parameter int ABORT_CLKS    = 4
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic [1:0]  rsp_status_o,
  output logic        lframe_o,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  input  logic [3:0]  lad_i,
  output logic        busy_o
);

  localparam int AW = $clog2(ABORT_CLKS + 1);
  localparam logic [AW-1:0] ABORT_LOAD = AW'(ABORT_CLKS - 1);

  host_state_e   state_q, state_d;
  logic          wr_q, err_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q, rdata_q;
  logic [AW-1:0] abort_cnt_q;
  logic          sync_go, sync_err, sync_abort;
  logic          lframe_d, oe_d;
  logic [3:0]    lad_d;

  assign req_ready_o = (state_q == ST_IDLE) && nrst_i;

  lpc_host_sync_mon #(
    .SYNC_TIMEOUT (SYNC_TIMEOUT),
    .LONG_WAIT_MAX(LONG_WAIT_MAX)
  ) u_sync_mon (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .en_i   (state_q == ST_SYNC),
    .lad_i  (lad_i),
    .go_o   (sync_go),
    .err_o  (sync_err),
    .abort_o(sync_abort)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid_i && req_ready_o) state_d = ST_START;
      ST_START:   state_d = ST_CYCTYPE;
      ST_CYCTYPE: state_d = ST_ADDR1;
      ST_ADDR1:   state_d = ST_ADDR2;
      ST_ADDR2:   state_d = ST_ADDR3;
      ST_ADDR3:   state_d = ST_ADDR4;
      ST_ADDR4:   state_d = wr_q ? ST_WDATA1 : ST_TAR1;
      ST_WDATA1:  state_d = ST_WDATA2;
      ST_WDATA2:  state_d = ST_TAR1;
      ST_TAR1:    state_d = ST_TAR2;
      ST_TAR2:    state_d = ST_SYNC;
      ST_SYNC: begin
        if (sync_abort)   state_d = ST_ABORT;
        else if (sync_go) state_d = wr_q ? ST_FTAR1 : ST_RDATA1;
      end
      ST_RDATA1:  state_d = ST_RDATA2;
      ST_RDATA2:  state_d = ST_FTAR1;
      ST_FTAR1:   state_d = ST_FTAR2;
      ST_FTAR2:   state_d = ST_IDLE;
      ST_ABORT:   if (abort_cnt_q == '0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bus drive decoded from the next state so the pins are plain flops.
  always_comb begin
    lframe_d = 1'b1;
    oe_d     = 1'b0;
    lad_d    = LPC_LAD_IDLE;
    case (state_d)
      ST_START:   begin lframe_d = 1'b0; oe_d = 1'b1; lad_d = LPC_START; end
      ST_CYCTYPE: begin oe_d = 1'b1; lad_d = wr_q ? LPC_CT_IO_WR : LPC_CT_IO_RD; end
      ST_ADDR1:   begin oe_d = 1'b1; lad_d = addr_q[15:12]; end
      ST_ADDR2:   begin oe_d = 1'b1; lad_d = addr_q[11:8]; end
      ST_ADDR3:   begin oe_d = 1'b1; lad_d = addr_q[7:4]; end
      ST_ADDR4:   begin oe_d = 1'b1; lad_d = addr_q[3:0]; end
      ST_WDATA1:  begin oe_d = 1'b1; lad_d = wdata_q[3:0]; end
      ST_WDATA2:  begin oe_d = 1'b1; lad_d = wdata_q[7:4]; end
      ST_TAR1:    oe_d = 1'b1;
      ST_ABORT:   begin lframe_d = 1'b0; oe_d = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= ST_IDLE;
      lframe_o     <= 1'b1;
      lad_oe_o     <= 1'b0;
      lad_o        <= LPC_LAD_IDLE;
      busy_o       <= 1'b0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      abort_cnt_q  <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= 8'h00;
      rsp_status_o <= RSP_OK;
    end else begin
      state_q  <= state_d;
      lframe_o <= lframe_d;
      lad_oe_o <= oe_d;
      lad_o    <= lad_d;
      busy_o   <= (state_d != ST_IDLE);

      if (state_q == ST_IDLE && state_d == ST_START) begin
        wr_q    <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        err_q   <= 1'b0;
      end
      if (state_q == ST_SYNC && sync_go && !sync_abort) err_q <= sync_err;
      if (state_q == ST_RDATA1) rdata_q[3:0] <= lad_i;
      if (state_q == ST_RDATA2) rdata_q[7:4] <= lad_i;

      if (state_q != ST_ABORT && state_d == ST_ABORT) abort_cnt_q <= ABORT_LOAD;
      else if (state_q == ST_ABORT && abort_cnt_q != '0) abort_cnt_q <= abort_cnt_q - 1'b1;

      rsp_valid_o <= 1'b0;
      if (state_q == ST_FTAR2) begin
        rsp_valid_o  <= 1'b1;
        rsp_status_o <= err_q ? RSP_ERR : RSP_OK;
        if (!wr_q) rsp_rdata_o <= rdata_q;
      end else if (state_q == ST_ABORT && state_d == ST_IDLE) begin
        rsp_valid_o  <= 1'b1;
        rsp_status_o <= RSP_ABORT;
        rsp_rdata_o  <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_lpc_host_io.sv
// Directed bench for lpc_host_io: bench plays the LPC peripheral and checks every bus cycle.
module tb_lpc_host_io;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [15:0] req_addr_i;
  logic [7:0]  req_wdata_i;
  logic        rsp_valid_o;
  logic [7:0]  rsp_rdata_o;
  logic [1:0]  rsp_status_o;
  logic        lframe_o, lad_oe_o, busy_o;
  logic [3:0]  lad_o, lad_i;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  lpc_host_io dut (
    .clk_i       (clk_i),
    .nrst_i      (nrst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_status_o(rsp_status_o),
    .lframe_o    (lframe_o),
    .lad_o       (lad_o),
    .lad_oe_o    (lad_oe_o),
    .lad_i       (lad_i),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus(input string tag, input logic lf, input logic oe, input logic [3:0] lad);
    chk({tag, "/lframe"}, 16'(lframe_o), 16'(lf));
    chk({tag, "/oe"}, 16'(lad_oe_o), 16'(oe));
    if (oe) chk({tag, "/lad"}, 16'(lad_o), 16'(lad));
  endtask

  task automatic rsp(input string tag, input logic [1:0] st, input logic [7:0] rd);
    chk({tag, "/rsp_valid"}, 16'(rsp_valid_o), 16'd1);
    chk({tag, "/status"}, 16'(rsp_status_o), 16'(st));
    chk({tag, "/rdata"}, 16'(rsp_rdata_o), 16'(rd));
    chk({tag, "/busy"}, 16'(busy_o), 16'd0);
  endtask

  task automatic issue(input string tag, input logic wr, input logic [15:0] addr,
                       input logic [7:0] wd, input logic hold);
    chk({tag, "/ready"}, 16'(req_ready_o), 16'd1);
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_valid_i = 1'b1;
    tick();
    if (!hold) req_valid_i = 1'b0;
    bus({tag, "/start"}, 1'b0, 1'b1, 4'h0);
  endtask

  // Full cycle with nwait wait codes followed by a terminating SYNC code.
  task automatic run_io(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wd, input int nwait, input logic [3:0] wcode,
                        input logic [3:0] fin, input logic [7:0] rd, input logic [1:0] exp_st,
                        input logic [7:0] exp_rd, input logic hold);
    int cyc;
    issue(tag, wr, addr, wd, hold);
    cyc = 0;
    tick(); cyc++; bus({tag, "/cyctype"}, 1'b1, 1'b1, wr ? 4'h2 : 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); cyc++; bus({tag, "/addr"}, 1'b1, 1'b1, addr[15-4*i -: 4]);
    end
    if (wr) begin
      tick(); cyc++; bus({tag, "/wdata1"}, 1'b1, 1'b1, wd[3:0]);
      tick(); cyc++; bus({tag, "/wdata2"}, 1'b1, 1'b1, wd[7:4]);
    end
    tick(); cyc++; bus({tag, "/tar1"}, 1'b1, 1'b1, 4'hF);
    tick(); cyc++; bus({tag, "/tar2"}, 1'b1, 1'b0, 4'hF);
    for (int i = 0; i <= nwait; i++) begin
      tick(); cyc++; bus({tag, "/sync"}, 1'b1, 1'b0, 4'hF);
      lad_i = (i < nwait) ? wcode : fin;
    end
    if (!wr) begin
      tick(); cyc++; bus({tag, "/rdata1"}, 1'b1, 1'b0, 4'hF); lad_i = rd[3:0];
      tick(); cyc++; bus({tag, "/rdata2"}, 1'b1, 1'b0, 4'hF); lad_i = rd[7:4];
    end
    tick(); cyc++; lad_i = 4'hF; bus({tag, "/ftar1"}, 1'b1, 1'b0, 4'hF);
    tick(); cyc++; bus({tag, "/ftar2"}, 1'b1, 1'b0, 4'hF);
    chk({tag, "/no_early_rsp"}, 16'(rsp_valid_o), 16'd0);
    tick(); cyc++;
    rsp(tag, exp_st, exp_rd);
    chk({tag, "/latency"}, 16'(cyc), 16'(13 + nwait));
  endtask

  // Read whose SYNC phase ends in abort after nsync cycles of the given code.
  task automatic run_abort(input string tag, input logic [15:0] addr, input logic [3:0] code,
                           input int nsync);
    issue(tag, 1'b0, addr, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    bus({tag, "/tar2"}, 1'b1, 1'b0, 4'hF);
    for (int i = 0; i < nsync; i++) begin
      tick(); bus({tag, "/sync"}, 1'b1, 1'b0, 4'hF);
      lad_i = code;
    end
    for (int i = 0; i < 4; i++) begin
      tick(); bus({tag, "/abort"}, 1'b0, 1'b1, 4'hF);
      lad_i = 4'hF;
    end
    tick();
    bus({tag, "/released"}, 1'b1, 1'b0, 4'hF);
    rsp(tag, 2'b10, 8'hFF);
    tick();
    chk({tag, "/rsp_pulse"}, 16'(rsp_valid_o), 16'd0);
    chk({tag, "/rdata_hold"}, 16'(rsp_rdata_o), 16'hFF);
  endtask

  initial begin
    nrst_i      = 1'b0;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    lad_i       = 4'hF;
    #12;
    chk("rst/ready", 16'(req_ready_o), 16'd0);
    chk("rst/lframe", 16'(lframe_o), 16'd1);
    chk("rst/oe", 16'(lad_oe_o), 16'd0);
    chk("rst/lad", 16'(lad_o), 16'hF);
    chk("rst/rsp_valid", 16'(rsp_valid_o), 16'd0);
    chk("rst/rdata", 16'(rsp_rdata_o), 16'h00);
    chk("rst/status", 16'(rsp_status_o), 16'd0);
    chk("rst/busy", 16'(busy_o), 16'd0);
    @(negedge clk_i) nrst_i = 1'b1;
    tick();

    // Write, immediate READY: LAD 0,2,0,0,8,0,5,A,F then turnaround.
    run_io("wr0080", 1'b1, 16'h0080, 8'hA5, 0, 4'h5, 4'h0, 8'h00, 2'b00, 8'h00, 1'b0);
    tick();
    chk("wr0080/rsp_pulse", 16'(rsp_valid_o), 16'd0);

    // Read with three short waits: 16 cycles from START to response.
    run_io("rd0C40", 1'b0, 16'h0C40, 8'h00, 3, 4'h5, 4'h0, 8'h3C, 2'b00, 8'h3C, 1'b0);
    tick();
    chk("rd0C40/rdata_hold", 16'(rsp_rdata_o), 16'h3C);

    // Error SYNC still completes data phase.
    run_io("rd_err", 1'b0, 16'h0003, 8'h00, 0, 4'h5, 4'hA, 8'h5A, 2'b01, 8'h5A, 1'b0);
    tick();

    // Long waits well beyond the short timeout must not abort.
    run_io("rd_long", 1'b0, 16'h0010, 8'h00, 20, 4'h6, 4'h0, 8'h81, 2'b00, 8'h81, 1'b0);
    tick();

    // Back-to-back with valid held: write leaves rdata alone, read follows immediately.
    run_io("b2b_wr", 1'b1, 16'h0060, 8'h3C, 0, 4'h5, 4'h0, 8'h00, 2'b00, 8'h81, 1'b1);
    run_io("b2b_rd", 1'b0, 16'h0064, 8'h00, 0, 4'h5, 4'h0, 8'hE7, 2'b00, 8'hE7, 1'b0);
    tick();

    // No responder: 8 SYNC cycles of F, then abort.
    run_abort("noresp", 16'h02F8, 4'hF, 8);
    // Undefined SYNC code aborts at once.
    run_abort("badsync", 16'h0100, 4'h3, 1);

    // Reset during ADDR2 releases the bus asynchronously.
    issue("rstmid", 1'b0, 16'h1234, 8'h00, 1'b0);
    tick(); tick(); tick();
    bus("rstmid/addr2", 1'b1, 1'b1, 4'h2);
    #2 nrst_i = 1'b0;
    #1;
    chk("rstmid/lframe", 16'(lframe_o), 16'd1);
    chk("rstmid/oe", 16'(lad_oe_o), 16'd0);
    chk("rstmid/lad", 16'(lad_o), 16'hF);
    chk("rstmid/ready", 16'(req_ready_o), 16'd0);
    chk("rstmid/rsp_valid", 16'(rsp_valid_o), 16'd0);
    chk("rstmid/rdata", 16'(rsp_rdata_o), 16'h00);
    chk("rstmid/busy", 16'(busy_o), 16'd0);
    @(negedge clk_i) nrst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid/no_rsp", 16'(rsp_valid_o), 16'd0);
      bus("rstmid/idle", 1'b1, 1'b0, 4'hF);
    end
    chk("rstmid/ready_after", 16'(req_ready_o), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
